// File: rtl/mem_port_arbiter_if.sv
// Bundle of the port-A write stream, the port-B request/ack channel and the
// memory-manager side of the arbiter.
interface mem_port_arbiter_if;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;

  logic          a_wr_valid;
  logic [AW-1:0] a_wr_addr;
  logic [DW-1:0] a_wr_data;
  logic          a_full;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic [DW-1:0] b_rdata;

  logic          mem_ready;
  logic          mem_wren;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_write;
  logic          mem_pause;
  logic [DW-1:0] mem_data_read;

  logic          timeout_err;

  // Arbiter side.
  modport slave (
    input  a_wr_valid, a_wr_addr, a_wr_data,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_ready, mem_pause, mem_data_read,
    output a_full, b_ack, b_rdata,
    output mem_wren, mem_address, mem_data_write,
    output timeout_err
  );

  // User logic plus memory-manager side.
  modport master (
    output a_wr_valid, a_wr_addr, a_wr_data,
    output b_req, b_we, b_addr, b_wdata,
    output mem_ready, mem_pause, mem_data_read,
    input  a_full, b_ack, b_rdata,
    input  mem_wren, mem_address, mem_data_write,
    input  timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-request memory manager: port A is a
// buffered streaming writer, port B a blocking read/write requester.
module mem_port_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic             clk_sync,
  input logic             rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

  state_t        state, state_n;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop;

  logic          wren_q, wren_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [DW-1:0] wdata_q, wdata_n;
  logic          ack_q, ack_n;
  logic [DW-1:0] rdata_q, rdata_n;
  logic          terr_q, terr_n;
  logic          last_grant, last_grant_n;   // 1 = port B won last
  logic          grant_b, grant_b_n;         // in-flight request belongs to B
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic          a_pend, pick_b;
  logic [DW-1:0] resp_data;

  assign full = (count == CW'(FIFO_DEPTH));
  // A pop frees a slot in the same cycle, so a push while full still lands.
  assign pop  = (state == RESP) && !grant_b;
  assign push = bus.a_wr_valid && (!full || pop);

  assign bus.a_full         = full;
  assign bus.mem_wren       = wren_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_data_write = wdata_q;
  assign bus.b_ack          = ack_q;
  assign bus.b_rdata        = rdata_q;
  assign bus.timeout_err    = terr_q;

  // FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk_sync) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.a_wr_addr;
      fifo_data[wr_ptr] <= bus.a_wr_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_sync or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Next-state, grant selection and next values of the registered outputs.
  always_comb begin
    state_n      = state;
    wren_n       = wren_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    ack_n        = 1'b0;
    rdata_n      = rdata_q;
    terr_n       = terr_q;
    last_grant_n = last_grant;
    grant_b_n    = grant_b;
    tmo_n        = tmo_cnt;
    a_pend       = (count != '0);
    pick_b       = bus.b_req && (!a_pend || (!full && !last_grant));
    resp_data    = wren_q ? wdata_q : bus.mem_data_read;

    case (state)
      IDLE: begin
        if (bus.mem_ready && (a_pend || bus.b_req)) begin
          state_n      = ISSUE;
          grant_b_n    = pick_b;
          last_grant_n = pick_b;
          tmo_n        = '0;
          if (pick_b) begin
            wren_n  = bus.b_we;
            addr_n  = bus.b_addr;
            wdata_n = bus.b_wdata;
          end else begin
            wren_n  = 1'b1;
            addr_n  = fifo_addr[rd_ptr];
            wdata_n = fifo_data[rd_ptr];
          end
        end
      end
      ISSUE: begin
        if (bus.mem_pause) begin
          state_n = WAIT_DONE;
          tmo_n   = '0;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          state_n = RESP;
          terr_n  = 1'b1;
          wren_n  = 1'b0;
          tmo_n   = '0;
          ack_n   = grant_b;
          if (grant_b) rdata_n = resp_data;
        end else begin
          tmo_n = tmo_cnt + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.mem_pause) begin
          state_n = RESP;
          wren_n  = 1'b0;
          ack_n   = grant_b;
          if (grant_b) rdata_n = resp_data;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk_sync or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      terr_q     <= 1'b0;
      last_grant <= 1'b1;
      grant_b    <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_n;
      wren_q     <= wren_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      ack_q      <= ack_n;
      rdata_q    <= rdata_n;
      terr_q     <= terr_n;
      last_grant <= last_grant_n;
      grant_b    <= grant_b_n;
      tmo_cnt    <= tmo_n;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory-manager pause model.
module tb_mem_port_arbiter;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 16;

  logic clk_sync = 1'b0;
  logic rst_n;
  always #5 clk_sync = ~clk_sync;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_sync (clk_sync),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Memory-manager model: pause rises one cycle after a write is presented
  // (or a read is requested), stays high hold_len cycles, then rests.
  logic model_en;
  int   hold_len;
  int   hold_cnt;
  int   cool_cnt;
  always @(posedge clk_sync or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_pause <= 1'b0;
      hold_cnt      <= 0;
      cool_cnt      <= 0;
    end else if (cool_cnt > 0) begin
      cool_cnt <= cool_cnt - 1;
    end else if (bus.mem_pause) begin
      if (hold_cnt <= 1) begin
        bus.mem_pause <= 1'b0;
        cool_cnt      <= 2;
      end else begin
        hold_cnt <= hold_cnt - 1;
      end
    end else if (model_en && (bus.mem_wren || (bus.b_req && !bus.b_we && bus.mem_ready))) begin
      bus.mem_pause <= 1'b1;
      hold_cnt      <= hold_len;
    end
  end

  // Observation: log each issued write, count acks and write-enable cycles.
  logic [17:0] log_addr [$];
  logic [31:0] log_data [$];
  logic        wren_d = 1'b0;
  int          ack_cnt = 0;
  int          wren_cyc = 0;
  always @(posedge clk_sync) begin
    wren_d <= bus.mem_wren;
    if (bus.mem_wren && !wren_d) begin
      log_addr.push_back(bus.mem_address);
      log_data.push_back(bus.mem_data_write);
    end
    if (bus.b_ack)    ack_cnt  <= ack_cnt + 1;
    if (bus.mem_wren) wren_cyc <= wren_cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk_sync);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.a_wr_valid = 1'b0;
    bus.a_wr_addr  = '0;
    bus.a_wr_data  = '0;
    bus.b_req      = 1'b0;
    bus.b_we       = 1'b0;
    bus.b_addr     = '0;
    bus.b_wdata    = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_a(input logic [17:0] addr, input logic [31:0] data);
    bus.a_wr_valid = 1'b1;
    bus.a_wr_addr  = addr;
    bus.a_wr_data  = data;
    tick();
    bus.a_wr_valid = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output bit seen, output logic [31:0] rd, output int cyc);
    seen = 1'b0;
    rd   = '0;
    cyc  = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      cyc = i + 1;
      if (bus.b_ack) begin
        seen = 1'b1;
        rd   = bus.b_rdata;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    logic [31:0] rd;
    int          cyc, base, ack0, wc0, k, j, popush, held_bad;
    logic        pop_now, full_now, acc;
    logic [31:0] echo;
    logic [17:0] exp_addr [6];

    rst_n             = 1'b0;
    model_en          = 1'b0;
    hold_len          = 2;
    bus.mem_ready     = 1'b0;
    bus.mem_data_read = '0;
    bus.a_wr_valid    = 1'b0;
    bus.a_wr_addr     = '0;
    bus.a_wr_data     = '0;
    bus.b_req         = 1'b0;
    bus.b_we          = 1'b0;
    bus.b_addr        = '0;
    bus.b_wdata       = '0;
    #1;
    check_eq("rst_a_full",   32'(bus.a_full), 32'd0);
    check_eq("rst_b_ack",    32'(bus.b_ack), 32'd0);
    check_eq("rst_b_rdata",  bus.b_rdata, 32'd0);
    check_eq("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
    check_eq("rst_mem_addr", 32'(bus.mem_address), 32'd0);
    check_eq("rst_mem_wdat", bus.mem_data_write, 32'd0);
    check_eq("rst_tmo_err",  32'(bus.timeout_err), 32'd0);
    do_reset();

    // Single port-B read.
    bus.mem_ready     = 1'b1;
    model_en          = 1'b1;
    bus.mem_data_read = 32'hDEADBEEF;
    ack0 = ack_cnt;
    wc0  = wren_cyc;
    bus.b_req  = 1'b1;
    bus.b_we   = 1'b0;
    bus.b_addr = 18'h00123;
    wait_ack(50, seen, rd, cyc);
    bus.b_req = 1'b0;
    repeat (5) tick();
    check_eq("rd_ack_seen", 32'(seen), 32'd1);
    check_eq("rd_data",     rd, 32'hDEADBEEF);
    check_eq("rd_ack_once", 32'(ack_cnt - ack0), 32'd1);
    check_eq("rd_no_wren",  32'(wren_cyc - wc0), 32'd0);
    check_eq("rd_addr_hold", 32'(bus.mem_address), 32'h00123);

    // Fill FIFO while memory is not ready; fifth push is dropped.
    do_reset();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_a(18'(32'h10 + i), 32'hA000_0000 + i);
    check_eq("fill_a_full", 32'(bus.a_full), 32'd1);
    base = log_addr.size();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 100 && (log_addr.size() - base) < 4; i++) tick();
    repeat (20) tick();
    check_eq("fill_wr_count", 32'(log_addr.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < log_addr.size()) begin
        check_eq($sformatf("fill_addr%0d", i), 32'(log_addr[base + i]), 32'h10 + i);
        check_eq($sformatf("fill_data%0d", i), log_data[base + i], 32'hA000_0000 + i);
      end
    end
    check_eq("fill_drained", 32'(bus.a_full), 32'd0);

    // Both ports pending: grants alternate starting with A.
    do_reset();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_a(18'(32'h100 + i), 32'h0000_AA00 + i);
    bus.b_req   = 1'b1;
    bus.b_we    = 1'b1;
    bus.b_addr  = 18'h200;
    bus.b_wdata = 32'h0000_BB00;
    base = log_addr.size();
    k    = 0;
    echo = '0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 200 && !(k == 3 && (log_addr.size() - base) >= 6); i++) begin
      tick();
      if (bus.b_ack) begin
        if (k == 0) echo = bus.b_rdata;
        k++;
        if (k < 3) begin
          bus.b_addr  = 18'(32'h200 + k);
          bus.b_wdata = 32'h0000_BB00 + k;
        end else begin
          bus.b_req = 1'b0;
        end
      end
    end
    exp_addr = '{18'h100, 18'h200, 18'h101, 18'h201, 18'h102, 18'h202};
    check_eq("alt_count", 32'(log_addr.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < log_addr.size())
        check_eq($sformatf("alt_grant%0d", i), 32'(log_addr[base + i]), 32'(exp_addr[i]));
    end
    check_eq("alt_wr_echo", echo, 32'h0000_BB00);

    // Pause never rises: timeout after 16 ISSUE cycles, then normal service.
    do_reset();
    repeat (3) tick();
    model_en          = 1'b0;
    bus.mem_ready     = 1'b1;
    bus.mem_data_read = 32'h1234_5678;
    check_eq("tmo_err_pre", 32'(bus.timeout_err), 32'd0);
    bus.b_req  = 1'b1;
    bus.b_we   = 1'b0;
    bus.b_addr = 18'h55;
    wait_ack(60, seen, rd, cyc);
    bus.b_req = 1'b0;
    check_eq("tmo_ack_seen", 32'(seen), 32'd1);
    check_eq("tmo_latency",  32'(cyc), 32'd17);
    check_eq("tmo_err_set",  32'(bus.timeout_err), 32'd1);
    check_eq("tmo_rdata",    rd, 32'h1234_5678);
    model_en = 1'b1;
    repeat (3) tick();
    bus.b_req   = 1'b1;
    bus.b_we    = 1'b1;
    bus.b_addr  = 18'h66;
    bus.b_wdata = 32'h0000_600D;
    wait_ack(50, seen, rd, cyc);
    bus.b_req = 1'b0;
    check_eq("tmo_next_ack",   32'(seen), 32'd1);
    check_eq("tmo_next_echo",  rd, 32'h0000_600D);
    check_eq("tmo_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Continuous pushes: pop and push while full, order kept across wraps.
    do_reset();
    bus.mem_ready = 1'b1;
    model_en      = 1'b1;
    base     = log_addr.size();
    j        = 0;
    popush   = 0;
    held_bad = 0;
    for (int i = 0; i < 600 && j < 20; i++) begin
      bus.a_wr_valid = 1'b1;
      bus.a_wr_addr  = 18'(32'h300 + j);
      bus.a_wr_data  = 32'hC000_0000 + j;
      pop_now  = !bus.mem_wren && wren_d;
      full_now = bus.a_full;
      acc      = !full_now || pop_now;
      tick();
      if (acc) j++;
      if (full_now && pop_now) begin
        popush++;
        if (!bus.a_full) held_bad++;
      end
    end
    bus.a_wr_valid = 1'b0;
    for (int i = 0; i < 400 && (log_addr.size() - base) < 20; i++) tick();
    check_eq("wrap_pushed",   32'(j), 32'd20);
    check_eq("wrap_popush",   32'(popush > 0), 32'd1);
    check_eq("wrap_full_held", 32'(held_bad), 32'd0);
    check_eq("wrap_count",    32'(log_addr.size() - base), 32'd20);
    for (int i = 0; i < 20; i++) begin
      if (base + i < log_addr.size())
        check_eq($sformatf("wrap_data%0d", i), log_data[base + i], 32'hC000_0000 + i);
    end

    // Reset asserted while a write is in WAIT_DONE.
    do_reset();
    hold_len      = 6;
    model_en      = 1'b1;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_a(18'(32'h400 + i), 32'hD000_0000 + i);
    bus.b_req   = 1'b1;
    bus.b_we    = 1'b1;
    bus.b_addr  = 18'h77;
    bus.b_wdata = 32'h0000_0077;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 20 && !bus.mem_pause; i++) tick();
    repeat (2) tick();
    check_eq("mid_wren_pre", 32'(bus.mem_wren), 32'd1);
    check_eq("mid_full_pre", 32'(bus.a_full), 32'd1);
    ack0 = ack_cnt;
    wc0  = wren_cyc;
    rst_n     = 1'b0;
    bus.b_req = 1'b0;
    #1;
    check_eq("mid_rst_wren",  32'(bus.mem_wren), 32'd0);
    check_eq("mid_rst_addr",  32'(bus.mem_address), 32'd0);
    check_eq("mid_rst_wdat",  bus.mem_data_write, 32'd0);
    check_eq("mid_rst_full",  32'(bus.a_full), 32'd0);
    check_eq("mid_rst_ack",   32'(bus.b_ack), 32'd0);
    check_eq("mid_rst_rdata", bus.b_rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check_eq("mid_no_ack",  32'(ack_cnt - ack0), 32'd0);
    check_eq("mid_no_wren", 32'(wren_cyc - wc0), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
